// File: rtl/bus_timer_array.sv
// Multi-channel interval timer on the 8-bit processor bus: shared prescaler,
// per-channel period counters, pending/overrun latches and one merged interrupt.
module bus_timer_array #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_CH    = 4,
  parameter int         PRESCALE  = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int            PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    CH_MASK  = 8'((1 << NUM_CH) - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    ovr_q, ovr_d;
  logic [7:0]    period_q [NUM_CH];
  logic [7:0]    period_d [NUM_CH];
  logic [7:0]    cnt_q [NUM_CH];
  logic [7:0]    cnt_d [NUM_CH];
  logic          raise_q, raise_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_vld_q, rd_vld_d;

  // Bus protocol: a write is taken on the edge where BUS_WE=1 and the address
  // hits the window; a read hit at edge N drives BUS_DATA from N until N+1.
  logic [7:0] offset;
  logic       hit, wr_en, rd_en;
  logic       wr_ctrl, wr_pend, wr_mask, wr_ovr, wr_per;
  logic [7:0] wdata;

  assign offset  = BUS_ADDR - BASE_ADDR;
  assign hit     = (offset < 8'd16);
  assign wr_en   = hit & BUS_WE;
  assign rd_en   = hit & ~BUS_WE;
  assign wdata   = BUS_DATA;
  assign wr_ctrl = wr_en && (offset[3:0] == 4'd0);
  assign wr_pend = wr_en && (offset[3:0] == 4'd1);
  assign wr_mask = wr_en && (offset[3:0] == 4'd2);
  assign wr_ovr  = wr_en && (offset[3:0] == 4'd4);
  assign wr_per  = wr_en && offset[3];

  logic       tick;
  logic [7:0] masked;
  logic       vec_any;
  logic [2:0] vec_idx;
  logic [7:0] vector;
  logic [7:0] ctrl_rise;
  logic [7:0] restart;
  logic [7:0] expire;
  logic [7:0] ack_clr;
  logic [7:0] rd_mux;

  assign tick    = (pre_q == PRE_LAST);
  assign masked  = pend_q & mask_q;
  assign vec_any = |masked;
  assign vector  = {vec_any, 4'b0000, vec_idx};

  always_comb begin
    vec_idx = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (masked[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    ctrl_d    = wr_ctrl ? (wdata & CH_MASK) : ctrl_q;
    mask_d    = wr_mask ? (wdata & CH_MASK) : mask_q;
    ctrl_rise = ctrl_d & ~ctrl_q;
  end

  // A period write or an enable edge restarts the count and cancels a
  // coincident expiry for that channel.
  always_comb begin
    expire  = '0;
    restart = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = (wr_per && (offset[2:0] == 3'(i))) ? wdata : period_q[i];
      restart[i]  = (wr_per && (offset[2:0] == 3'(i))) || ctrl_rise[i];
      cnt_d[i]    = cnt_q[i];
      if (!ctrl_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (period_q[i] != 8'd0)) begin
        if (cnt_q[i] == period_q[i] - 8'd1) begin
          cnt_d[i]  = '0;
          expire[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
      if (restart[i]) begin
        cnt_d[i]  = '0;
        expire[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (BUS_INTERRUPT_ACK && vec_any) ack_clr[vec_idx] = 1'b1;
    pend_d  = ((pend_q & ~(wr_pend ? wdata : 8'h00) & ~ack_clr) | expire) & CH_MASK;
    ovr_d   = ((ovr_q & ~(wr_ovr ? wdata : 8'h00)) | (expire & pend_q)) & CH_MASK;
    raise_d = vec_any;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (offset[3:0])
      4'd0:    rd_mux = ctrl_q;
      4'd1:    rd_mux = pend_q;
      4'd2:    rd_mux = mask_q;
      4'd3:    rd_mux = vector;
      4'd4:    rd_mux = ovr_q;
      default: begin
        if (offset[3]) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (offset[2:0] == 3'(i)) rd_mux = period_q[i];
          end
        end
      end
    endcase
    rd_data_d = rd_en ? rd_mux : 8'h00;
    rd_vld_d  = rd_en;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q     <= '0;
      ctrl_q    <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      ovr_q     <= '0;
      raise_q   <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      ovr_q     <= ovr_d;
      raise_q   <= raise_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign BUS_INTERRUPT_RAISE = raise_q;
  assign BUS_DATA            = rd_vld_q ? rd_data_q : 8'hzz;

endmodule
